// File: rtl/load_store_unit.sv
// Load/store unit: one core request -> one Avalon-MM read or write with lane steering.
// Define LSU_BUS_TIMEOUT_EN to add a waitrequest watchdog of TIMEOUT_CYCLES cycles.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o,
    output logic        timeout_o,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mis_q, mis_d;
    logic        misaligned;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_val;

`ifdef LSU_BUS_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_q, to_d;
`endif

    always_comb begin
        unique case (size_i)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = addr_i[0];
            2'b10:   misaligned = |addr_i[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        lane_b = readdata[{off_q, 3'b000} +: 8];
        lane_h = off_q[1] ? readdata[31:16] : readdata[15:0];
        unique case (size_q)
            2'b00:   load_val = {{24{lane_b[7] & ~uns_q}}, lane_b};
            2'b01:   load_val = {{16{lane_h[15] & ~uns_q}}, lane_h};
            default: load_val = readdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        off_d   = off_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        mis_d   = mis_q;
`ifdef LSU_BUS_TIMEOUT_EN
        cnt_d   = cnt_q;
        to_d    = to_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    we_d   = we_i;
                    size_d = size_i;
                    uns_d  = unsigned_i;
                    off_d  = addr_i[1:0];
                    mis_d  = misaligned;
`ifdef LSU_BUS_TIMEOUT_EN
                    cnt_d  = '0;
                    to_d   = 1'b0;
`endif
                    if (misaligned) begin
                        rdata_d = '0;
                        state_d = RESP;
                    end else begin
                        addr_d = {addr_i[31:2], 2'b00};
                        unique case (size_i)
                            2'b00: begin
                                be_d    = 4'b0001 << addr_i[1:0];
                                wdata_d = {4{wdata_i[7:0]}};
                            end
                            2'b01: begin
                                be_d    = addr_i[1] ? 4'b1100 : 4'b0011;
                                wdata_d = {2{wdata_i[15:0]}};
                            end
                            default: begin
                                be_d    = 4'b1111;
                                wdata_d = wdata_i;
                            end
                        endcase
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (!waitrequest) begin
                    if (!we_q) rdata_d = load_val;
                    state_d = RESP;
                end
`ifdef LSU_BUS_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    to_d    = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            off_q   <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
        end
    end

`ifdef LSU_BUS_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign timeout_o = done_o & to_q;
`else
    assign timeout_o = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    // Bus strobes decode straight from state so reset drops them immediately
    assign read         = (state_q == ACCESS) & ~we_q;
    assign write        = (state_q == ACCESS) & we_q;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == RESP);
    assign misaligned_o = done_o & mis_q;
    assign rdata_o      = rdata_q;
    assign address      = addr_q;
    assign writedata    = wdata_q;
    assign byteenable   = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random
// transactions against an arithmetic lane/extension model and random wait states.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_i;
    logic        we_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        misaligned_o;
    logic        timeout_o;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_rd = '0;

    load_store_unit dut (
        .clk(clk), .reset(reset), .req_i(req_i), .we_i(we_i),
        .size_i(size_i), .unsigned_i(unsigned_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o),
        .rdata_o(rdata_o), .misaligned_o(misaligned_o),
        .timeout_o(timeout_o), .address(address), .read(read),
        .write(write), .waitrequest(waitrequest),
        .writedata(writedata), .byteenable(byteenable),
        .readdata(readdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit is_mis(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 1'b1;
        return (a % nbytes(sz)) != 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                           input int k, input logic [31:0] rd);
        int bits;
        logic [31:0] v, mask;
        bits = 8 * nbytes(sz);
        if (bits == 32) return rd;
        mask = (32'd1 << bits) - 32'd1;
        v = (rd >> (8 * k)) & mask;
        if (!uns && v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input int k);
        return 4'(((1 << nbytes(sz)) - 1) << k);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = w[8*(i % nbytes(sz)) +: 8];
        return r;
    endfunction

    task automatic txn(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int waits, input logic [31:0] rd);
        int k;
        k = int'(a[1:0]);
        @(negedge clk);
        req_i = 1'b1; we_i = we; size_i = sz; unsigned_i = uns;
        addr_i = a; wdata_i = wd; readdata = rd;
        waitrequest = (waits > 0);
        chk("idle_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        req_i = 1'b0;
        if (is_mis(sz, a)) begin
            exp_rd = '0;
            chk("mis_done", 32'(done_o), 32'd1);
            chk("mis_flag", 32'(misaligned_o), 32'd1);
            chk("mis_rw", 32'({read, write}), 32'd0);
            chk("mis_rdata", rdata_o, exp_rd);
        end else begin
            for (int c = 0; c <= waits; c++) begin
                waitrequest = (c < waits);
                if (c == 1) begin
                    req_i = 1'b1; we_i = ~we; addr_i = $urandom;
                    size_i = 2'($urandom); wdata_i = $urandom;
                end else begin
                    req_i = 1'b0;
                end
                chk("acc_read", 32'(read), 32'(!we));
                chk("acc_write", 32'(write), 32'(we));
                chk("acc_addr", address, {a[31:2], 2'b00});
                chk("acc_be", 32'(byteenable), 32'(m_be(sz, k)));
                if (we) chk("acc_wdata", writedata, m_wdata(sz, wd));
                chk("acc_nodone", 32'(done_o), 32'd0);
                chk("acc_busy", 32'(busy_o), 32'd1);
                @(negedge clk);
            end
            req_i = 1'b0;
            if (!we) exp_rd = m_load(sz, uns, k, rd);
            chk("resp_done", 32'(done_o), 32'd1);
            chk("resp_rw", 32'({read, write}), 32'd0);
            chk("resp_busy", 32'(busy_o), 32'd1);
            chk("resp_mis", 32'(misaligned_o), 32'd0);
            chk("resp_rdata", rdata_o, exp_rd);
        end
        chk("resp_to", 32'(timeout_o), 32'd0);
        @(negedge clk);
        chk("post_done", 32'(done_o), 32'd0);
        chk("post_busy", 32'(busy_o), 32'd0);
        chk("post_rdata", rdata_o, exp_rd);
    endtask

    initial begin
        reset = 1'b1; req_i = 1'b0; we_i = 1'b0; size_i = 2'd0;
        unsigned_i = 1'b0; addr_i = '0; wdata_i = '0;
        waitrequest = 1'b0; readdata = '0;
        #12;
        chk("rst_rw", 32'({read, write, done_o, busy_o}), 32'd0);
        chk("rst_addr", address, 32'd0);
        chk("rst_be", 32'(byteenable), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_flags", 32'({misaligned_o, timeout_o}), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        txn(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 0, 32'hDEADBEEF);
        chk("lw_val", rdata_o, 32'hDEADBEEF);
        txn(1'b0, 2'd0, 1'b0, 32'h1003, 32'h0, 0, 32'h80112233);
        chk("lb_s_val", rdata_o, 32'hFFFFFF80);
        txn(1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 0, 32'h80112233);
        chk("lb_u_val", rdata_o, 32'h00000080);
        txn(1'b1, 2'd1, 1'b0, 32'h2002, 32'h0000ABCD, 0, 32'h0);
        chk("sh_keep", rdata_o, 32'h00000080);
        txn(1'b0, 2'd1, 1'b0, 32'h2001, 32'h0, 0, 32'h12345678);
        chk("lh_mis_val", rdata_o, 32'h0);
        txn(1'b1, 2'd2, 1'b0, 32'h3004, 32'hCAFEF00D, 5, 32'h0);
        txn(1'b0, 2'd1, 1'b0, 32'h0002, 32'h0, 2, 32'h9234_0000);
        chk("lh_s_val", rdata_o, 32'hFFFF9234);

        for (int n = 0; n < 300; n++)
            txn(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
                int'($urandom_range(0, 3)), $urandom);

        @(negedge clk);
        req_i = 1'b1; we_i = 1'b0; size_i = 2'd2; addr_i = 32'h44;
        waitrequest = 1'b1;
        @(negedge clk);
        req_i = 1'b0;
        @(negedge clk);
        chk("rst_pre_read", 32'(read), 32'd1);
        #2 reset = 1'b1;
        #1 chk("rst_async_read", 32'(read), 32'd0);
        chk("rst_async_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        waitrequest = 1'b0;
        exp_rd = '0;
        for (int c = 0; c < 3; c++) begin
            chk("rst_nodone", 32'(done_o), 32'd0);
            @(negedge clk);
        end
        chk("rst_rdata0", rdata_o, exp_rd);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
